// File: rtl/tpu_mm_sequencer_if.sv
// tpu_mm_sequencer_if: host/datapath signal bundle of the matrix-multiply sequencer.
// The run_cycles signal is present only when TPU_SEQ_CYCLE_CNT_EN is defined.
interface tpu_mm_sequencer_if #(
   parameter int ROWW = 3
);
   logic            start;
   logic            clr_c;
   logic            abort;
   logic [ROWW-1:0] host_crow;
   logic            enA;
   logic            enB;
   logic            enS;
   logic            WrEnS;
   logic            cin_zero;
   logic [ROWW-1:0] crow;
   logic            busy;
   logic            done;
   logic            aborted;
`ifdef TPU_SEQ_CYCLE_CNT_EN
   logic [15:0]     run_cycles;
`endif

   // Host / decode side: issues requests, observes the sequencer.
   modport master (
      output start, clr_c, abort, host_crow,
      input  enA, enB, enS, WrEnS, cin_zero, crow, busy, done, aborted
`ifdef TPU_SEQ_CYCLE_CNT_EN
      , input run_cycles
`endif
   );

   // Sequencer side.
   modport slave (
      input  start, clr_c, abort, host_crow,
      output enA, enB, enS, WrEnS, cin_zero, crow, busy, done, aborted
`ifdef TPU_SEQ_CYCLE_CNT_EN
      , output run_cycles
`endif
   );
endinterface

// File: rtl/tpu_mm_sequencer.sv
// tpu_mm_sequencer: control FSM for one matrix-multiply pass of the TPU datapath.
// IDLE -> (optional CLEAR of DIM accumulator rows) -> RUN for 3*DIM-2 cycles -> DONE.
// Optional busy-cycle counter enabled by defining TPU_SEQ_CYCLE_CNT_EN.
module tpu_mm_sequencer #(
   parameter int DIM  = 8,
   parameter int ROWW = $clog2(DIM),
   parameter int CNTW = $clog2(3*DIM)
) (
   input logic                clk,
   input logic                rst_n,
   tpu_mm_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Terminal counts: CLEAR lasts DIM cycles, RUN lasts 3*DIM-2 cycles.
   localparam logic [CNTW-1:0] CLEAR_LAST = CNTW'(DIM - 1);
   localparam logic [CNTW-1:0] RUN_LAST   = CNTW'(3*DIM - 3);

   state_e          state_q, state_d;
   logic [CNTW-1:0] cnt_q,   cnt_d;
   logic            clr_q,   clr_d;
   logic            aborted_q, aborted_d;

   // Next-state logic: pass sequencing, abort handling, phase counter.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      clr_d     = clr_q;
      aborted_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // start wins over a simultaneous abort; abort alone is ignored here
            if (bus.start) begin
               cnt_d   = {CNTW{1'b0}};
               clr_d   = bus.clr_c;
               state_d = bus.clr_c ? ST_CLEAR : ST_RUN;
            end else begin
               cnt_d   = {CNTW{1'b0}};
            end
         end
         ST_CLEAR: begin
            if (bus.abort) begin
               state_d   = ST_IDLE;
               cnt_d     = {CNTW{1'b0}};
               aborted_d = 1'b1;
            end else if (cnt_q == CLEAR_LAST) begin
               state_d = ST_RUN;
               cnt_d   = {CNTW{1'b0}};
            end else begin
               cnt_d   = cnt_q + CNTW'(1);
            end
         end
         ST_RUN: begin
            if (bus.abort) begin
               state_d   = ST_IDLE;
               cnt_d     = {CNTW{1'b0}};
               aborted_d = 1'b1;
            end else if (cnt_q == RUN_LAST) begin
               state_d = ST_DONE;
               cnt_d   = {CNTW{1'b0}};
            end else begin
               cnt_d   = cnt_q + CNTW'(1);
            end
         end
         ST_DONE: begin
            // late abort or start is ignored; the pass still completes
            state_d = ST_IDLE;
            cnt_d   = {CNTW{1'b0}};
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = {CNTW{1'b0}};
         end
      endcase
   end

   // State, phase counter, clear flag and abort pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= {CNTW{1'b0}};
         clr_q     <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         clr_q     <= clr_d;
         aborted_q <= aborted_d;
      end
   end

   // Moore output decode; crow follows the host except while clearing rows.
   always_comb begin
      bus.enA      = 1'b0;
      bus.enB      = 1'b0;
      bus.enS      = 1'b0;
      bus.WrEnS    = 1'b0;
      bus.cin_zero = 1'b0;
      bus.done     = 1'b0;
      bus.busy     = 1'b0;
      bus.crow     = bus.host_crow;
      case (state_q)
         ST_CLEAR: begin
            bus.WrEnS    = clr_q;
            bus.cin_zero = clr_q;
            bus.crow     = cnt_q[ROWW-1:0];
            bus.busy     = 1'b1;
         end
         ST_RUN: begin
            bus.enA  = 1'b1;
            bus.enB  = 1'b1;
            bus.enS  = 1'b1;
            bus.busy = 1'b1;
         end
         ST_DONE: begin
            bus.done = 1'b1;
            bus.busy = 1'b1;
         end
         default: begin
            bus.busy = 1'b0;
         end
      endcase
   end

   assign bus.aborted = aborted_q;

`ifdef TPU_SEQ_CYCLE_CNT_EN
   logic [15:0] run_cycles_q, run_cycles_d;
   logic        in_pass_s;

   assign in_pass_s = (state_q != ST_IDLE);

   // Busy-cycle counter: cleared on accepted start, saturating, held between passes.
   always_comb begin
      run_cycles_d = run_cycles_q;
      if ((state_q == ST_IDLE) && bus.start) begin
         run_cycles_d = 16'h0000;
      end else if (in_pass_s && (run_cycles_q != 16'hFFFF)) begin
         run_cycles_d = run_cycles_q + 16'h0001;
      end else begin
         run_cycles_d = run_cycles_q;
      end
   end

   // Busy-cycle counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_cycles_q <= 16'h0000;
      end else begin
         run_cycles_q <= run_cycles_d;
      end
   end

   assign bus.run_cycles = run_cycles_q;
`endif

endmodule

// File: tb/tb_tpu_mm_sequencer.sv
// tb_tpu_mm_sequencer: directed + randomized bench for tpu_mm_sequencer (DIM=8).
// A pass-level model (position within a pass of known length) predicts every output.
module tb_tpu_mm_sequencer;
   localparam int DIM  = 8;
   localparam int ROWW = 3;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   tpu_mm_sequencer_if #(.ROWW(ROWW)) bus ();

   tpu_mm_sequencer #(.DIM(DIM)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // A pass is a run of busy cycles numbered 0..len-1: with a clear the first
   // DIM are row clears, the last one is the done cycle, the rest compute.
   bit m_in_pass;
   int m_p;
   int m_len;
   bit m_clr;
   bit m_aborted;
   int m_runc;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_in_pass = 1'b0; m_p = 0; m_len = 0; m_clr = 1'b0;
         m_aborted = 1'b0; m_runc = 0;
      end else begin
         m_aborted = 1'b0;
         if (!m_in_pass) begin
            if (bus.start) begin
               m_in_pass = 1'b1;
               m_p       = 0;
               m_clr     = bus.clr_c;
               m_len     = bus.clr_c ? (4*DIM - 1) : (3*DIM - 1);
               m_runc    = 0;
            end
         end else begin
            if (m_runc < 65535) m_runc++;
            if (bus.abort && (m_p < m_len - 1)) begin
               m_in_pass = 1'b0;
               m_aborted = 1'b1;
            end else begin
               m_p++;
               if (m_p == m_len) m_in_pass = 1'b0;
            end
         end
      end
   end

   // Compare every output against the model on each falling edge.
   always @(negedge clk) begin
      bit clear_ph, done_ph, run_ph;
      clear_ph = m_in_pass && m_clr && (m_p < DIM);
      done_ph  = m_in_pass && (m_p == m_len - 1);
      run_ph   = m_in_pass && !clear_ph && !done_ph;
      check("busy",     32'(bus.busy),     32'(m_in_pass));
      check("done",     32'(bus.done),     32'(done_ph));
      check("aborted",  32'(bus.aborted),  32'(m_aborted));
      check("enA",      32'(bus.enA),      32'(run_ph));
      check("enB",      32'(bus.enB),      32'(run_ph));
      check("enS",      32'(bus.enS),      32'(run_ph));
      check("WrEnS",    32'(bus.WrEnS),    32'(clear_ph));
      check("cin_zero", 32'(bus.cin_zero), 32'(clear_ph));
      check("crow",     32'(bus.crow),     clear_ph ? 32'(m_p) : 32'(bus.host_crow));
`ifdef TPU_SEQ_CYCLE_CNT_EN
      check("run_cycles", 32'(bus.run_cycles), 32'(m_runc));
`endif
   end

   // ---------------- stimulus helpers ----------------
   task automatic pulse_start(input logic clr);
      @(posedge clk); #1;
      bus.start = 1'b1; bus.clr_c = clr;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.clr_c = 1'b0;
   endtask

   // Full pass with literal expectations on the cycle counts and crow order.
   task automatic full_pass(input logic clr, input int exp_busy, input int exp_ens,
                            input int exp_wr);
      int n_busy, n_ens, n_wr, n_done;
      n_busy = 0; n_ens = 0; n_wr = 0; n_done = 0;
      pulse_start(clr);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.busy) n_busy++;
         if (bus.enS) n_ens++;
         if (bus.done) n_done++;
         if (bus.WrEnS) begin
            check("lit_clear_row", 32'(bus.crow), 32'(n_wr));
            n_wr++;
         end
      end
      check("lit_busy_cycles", 32'(n_busy), 32'(exp_busy));
      check("lit_ens_cycles",  32'(n_ens),  32'(exp_ens));
      check("lit_wr_cycles",   32'(n_wr),   32'(exp_wr));
      check("lit_done_pulses", 32'(n_done), 32'd1);
`ifdef TPU_SEQ_CYCLE_CNT_EN
      check("lit_run_cycles", 32'(bus.run_cycles), 32'(exp_busy));
`endif
   endtask

   initial begin
      int n_done;
      checks = 0; failures = 0;
      bus.start = 1'b0; bus.clr_c = 1'b0; bus.abort = 1'b0; bus.host_crow = '0;
      rst_n = 1'b0;
      #23 rst_n = 1'b1;

      // Idle: crow follows host, nothing enabled.
      @(posedge clk); #1 bus.host_crow = 3'd5;
      @(negedge clk);
      check("lit_idle_crow",  32'(bus.crow),  32'd5);
      check("lit_idle_wr",    32'(bus.WrEnS), 32'd0);
      check("lit_idle_busy",  32'(bus.busy),  32'd0);

      full_pass(1'b1, 31, 22, 8);
      full_pass(1'b0, 23, 22, 0);

      // Abort on the 5th RUN cycle.
      n_done = 0;
      pulse_start(1'b0);
      for (int i = 1; i <= 4; i++) @(posedge clk);
      #1 bus.abort = 1'b1;
      @(posedge clk); #1 bus.abort = 1'b0;
      @(negedge clk);
      check("lit_abort_ens",     32'(bus.enS),     32'd0);
      check("lit_abort_pulse",   32'(bus.aborted), 32'd1);
      @(negedge clk);
      check("lit_abort_pulse_end", 32'(bus.aborted), 32'd0);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.done) n_done++;
      end
      check("lit_abort_no_done", 32'(n_done), 32'd0);
      full_pass(1'b0, 23, 22, 0);

      // start pulsed during RUN and during DONE: exactly one done.
      n_done = 0;
      pulse_start(1'b0);
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         bus.start = (i == 10 || i == 22) ? 1'b1 : 1'b0;
         @(negedge clk);
         if (bus.done) n_done++;
      end
      check("lit_ignored_start_done", 32'(n_done),   32'd1);
      check("lit_ignored_start_idle", 32'(bus.busy), 32'd0);

      // Asynchronous reset in the middle of CLEAR.
      pulse_start(1'b1);
      @(posedge clk); @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("lit_rst_busy",  32'(bus.busy),     32'd0);
      check("lit_rst_wr",    32'(bus.WrEnS),    32'd0);
      check("lit_rst_cinz",  32'(bus.cin_zero), 32'd0);
      check("lit_rst_crow",  32'(bus.crow),     32'd5);
      @(posedge clk); #3 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("lit_rst_idle", 32'(bus.busy), 32'd0);
      full_pass(1'b1, 31, 22, 8);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         @(posedge clk); #1;
         bus.start     = ($urandom_range(0, 7) == 0);
         bus.clr_c     = $urandom_range(0, 1) == 1;
         bus.abort     = ($urandom_range(0, 39) == 0);
         bus.host_crow = 3'($urandom_range(0, 7));
      end
      @(posedge clk); #1;
      bus.start = 1'b0; bus.abort = 1'b0;
      repeat (40) @(posedge clk);
      @(negedge clk); #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
